i2c_reg_ctrl: RTL and testbench
===============================

# i2c_reg_ctrl

Register-access sequencer that drives the byte-level I2C engine (`i2c_raw`) on behalf of the CPU. It accepts one single-register read or write command and issues the full I2C transaction:
- START, address, register index, data, STOP for a write;
- START, address, register index, repeated START, address+R, one read byte with NACK, STOP for a read.

It reports completion, read data and a failure code. It sits between the CPU I/O register file and `i2c_raw`, and owns all `i2c_raw` control inputs.

## Interface
- `TIMEOUT_CYCLES`, default 4096: watchdog limit per byte in clk cycles (used only with the timeout macro).

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req`  in  1  start command; sampled only in IDLE.
- `req_we`  in  1  1 = register write, 0 = register read.
- `dev_addr`  in  7  7-bit slave address.
- `reg_addr`  in  8  register index.
- `wdata`  in  8  write data.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  2  result code:
  - 00 ok
  - 01 address NACK
  - 10 register/data NACK
  - 11 timeout
- `rdata`  out  8  read result.
- `tx_start`  out  1  one-cycle byte launch to `i2c_raw`.
- `cnd_start`  out  1  generate START before this byte.
- `cnd_stop`  out  1  generate STOP after this byte.
- `rw`  out  1  0 = transmit byte, 1 = receive byte.
- `tx_data`  out  8  byte to transmit.
- `tx_ack`  out  1  ACK bit sent on a receive byte (1 = NACK).
- `tx_ready`  in  1  `i2c_raw` idle and ready.
- `rx_ack`  in  1  ACK bit sampled from the slave (0 = ACK).
- `rx_data`  in  8  byte received.

## Operation
- Reset values:
  - `busy`, `done`, `tx_start`, `cnd_start`, `cnd_stop`, `rw`, `tx_ack` = 0.
  - `err` = 00, `rdata` = 0x00, `tx_data` = 0x00.
  - State IDLE, byte index 0.
- Command capture: in IDLE, `req`=1 latches `req_we`, `dev_addr`, `reg_addr`, `wdata`, clears `err`, sets index 0 and moves to ISSUE. `req` while busy is ignored.
- Byte sequence (index → `tx_data`/`rw`/`cnd_start`/`cnd_stop`/`tx_ack`):
  - Write: 0 → {dev,0}/0/1/0; 1 → reg/0/0/0; 2 → wdata/0/0/1 (last).
  - Read: 0 → {dev,0}/0/1/0; 1 → reg/0/0/0; 2 → {dev,1}/0/1/0; 3 → don't-care/1/0/1/tx_ack=1 (last).
- States:
  - IDLE.
  - ISSUE: wait `tx_ready`=1, then pulse `tx_start` for 1 cycle with the byte controls stable; → WAIT_LO.
  - WAIT_LO: wait `tx_ready`=0 → WAIT_HI.
  - WAIT_HI: wait `tx_ready`=1 → CHECK.
  - CHECK: evaluates the byte just finished:
    - Transmit byte with `rx_ack`=1 on index 0 or 2: `err`=01.
    - Transmit byte with `rx_ack`=1 on index 1, or on write index 2: `err`=10.
    - On any NACK with no STOP yet issued → RECOVER. NACK on the last (STOP-carrying) byte → DONE.
    - Last byte with ACK (or the read byte): latch `rdata`=`rx_data` for reads → DONE.
    - Otherwise index+1 → ISSUE.
  - RECOVER: issue one receive byte (`rw`=1, `tx_ack`=1, `cnd_stop`=1, `cnd_start`=0) so the bus is released by a STOP. Uses the same ISSUE/WAIT_LO/WAIT_HI handshake, then → DONE. `rdata` is not updated.
  - DONE: `done`=1 for one cycle, `busy`=0 in the same cycle; → IDLE.
- `busy`=1 in every state except IDLE and DONE.
- `rx_ack` on the read byte (index 3) is ignored.
- Reset mid-operation forces IDLE on the next edge. `i2c_raw` shares `rst`, so the bus is released by the engine's own reset.

## Timing
- `req` sampled at edge N → `busy`=1 after N. Earliest `tx_start` pulse is the cycle after N+1 if `tx_ready`=1.
- Byte controls (`tx_data`, `rw`, `cnd_*`, `tx_ack`) are registered. They are set on entry to ISSUE and held until the next ISSUE.
- `tx_start` is never asserted while `tx_ready`=0.
- `tx_start` never stays high for more than 1 cycle.
- `err` and `rdata` are valid from the `done` cycle and hold until the next accepted `req`.
- Controller overhead per byte: ≤3 cycles beyond the `i2c_raw` byte time.

## Configuration
- `I2C_REG_CTRL_TIMEOUT_EN` defined:
  - A per-byte counter runs in WAIT_LO/WAIT_HI and clears on each ISSUE.
  - Reaching `TIMEOUT_CYCLES` sets `err`=11 and goes straight to DONE with no recovery byte.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
- Not defined: no counter; the controller waits indefinitely and `err`=11 is never produced.

## Test plan
- Write with all bytes ACKed: dev=0x1A, reg=0x35, wdata=0xC3, req_we=1.
  - Bytes 0x34(START), 0x35, 0xC3(STOP).
  - done=1 once, err=00, busy low after done.
- Read: dev=0x1A, reg=0x10; slave ACKs and returns 0x5A.
  - Bytes 0x34(START), 0x10, 0x35(START), receive with tx_ack=1 and STOP.
  - rdata=0x5A, err=00.
- Address NACK on byte 0 (rx_ack=1):
  - One recovery receive byte with cnd_stop=1.
  - err=01, rdata unchanged; no further transmit bytes.
- NACK on wdata byte of a write: err=10, done directly with no recovery byte.
- Second req while busy and mid-transaction rst:
  - The second req is ignored (no extra tx_start).
  - After rst, all outputs are at reset values and state is IDLE.
- With `I2C_REG_CTRL_TIMEOUT_EN`, TIMEOUT_CYCLES=64, tx_ready held 0 after launch:
  - err=11 and done exactly 64 cycles after the WAIT_LO entry.

Source files
------------

// File: rtl/i2c_reg_ctrl_if.sv
// i2c_reg_ctrl_if: CPU command bus and i2c_raw byte-engine bus of the register sequencer
interface i2c_reg_ctrl_if;
    logic       req;
    logic       req_we;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic [7:0] rdata;
    logic       tx_start;
    logic       cnd_start;
    logic       cnd_stop;
    logic       rw;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       tx_ready;
    logic       rx_ack;
    logic [7:0] rx_data;
    modport master (
        input  req, req_we, dev_addr, reg_addr, wdata, tx_ready, rx_ack, rx_data,
        output busy, done, err, rdata, tx_start, cnd_start, cnd_stop, rw, tx_data, tx_ack
    );
    modport slave (
        output req, req_we, dev_addr, reg_addr, wdata, tx_ready, rx_ack, rx_data,
        input  busy, done, err, rdata, tx_start, cnd_start, cnd_stop, rw, tx_data, tx_ack
    );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: single-register I2C read/write sequencer over i2c_raw; define I2C_REG_CTRL_TIMEOUT_EN for a per-byte watchdog
module i2c_reg_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    i2c_reg_ctrl_if.master    bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, CHECK, RECOVER, DONE} state_t;
    state_t      state, state_n;
    logic [1:0]  idx, idx_n, err, err_n;
    logic [7:0]  rdata, rdata_n, ra, ra_n, wd, wd_n;
    logic [6:0]  dev, dev_n;
    logic        we, we_n, start, start_n;
    logic [11:0] ctl, ctl_n;
`ifdef I2C_REG_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_n;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif
    // byte controls packed as {tx_data, rw, cnd_start, cnd_stop, tx_ack}
    function automatic logic [11:0] ctl_for(input logic [1:0] i, input logic w, input logic [6:0] d,
                                            input logic [7:0] r, input logic [7:0] v);
        return (i == 2'd0) ? {d, 1'b0, 4'b0100} :
               (i == 2'd1) ? {r, 4'b0000} :
               (i == 2'd3) ? {8'h00, 4'b1011} :
               w ? {v, 4'b0010} : {d, 1'b1, 4'b0100};
    endfunction
    always_comb begin
        state_n = state;
        idx_n   = idx;
        err_n   = err;
        rdata_n = rdata;
        we_n    = we;
        dev_n   = dev;
        ra_n    = ra;
        wd_n    = wd;
        ctl_n   = ctl;
        start_n = 1'b0;
        case (state)
            IDLE: if (bus.req) begin
                state_n = ISSUE;
                idx_n   = 2'd0;
                err_n   = 2'b00;
                we_n    = bus.req_we;
                dev_n   = bus.dev_addr;
                ra_n    = bus.reg_addr;
                wd_n    = bus.wdata;
                ctl_n   = ctl_for(2'd0, bus.req_we, bus.dev_addr, bus.reg_addr, bus.wdata);
            end
            ISSUE: if (bus.tx_ready) begin
                start_n = 1'b1;
                state_n = WAIT_LO;
            end
            WAIT_LO: state_n = bus.tx_ready ? WAIT_LO : WAIT_HI;
            WAIT_HI: state_n = bus.tx_ready ? CHECK : WAIT_HI;
            // a receive byte is either the read data byte (index 3) or the recovery byte
            CHECK: if (ctl[3]) begin
                rdata_n = (idx == 2'd3) ? bus.rx_data : rdata;
                state_n = DONE;
            end else if (bus.rx_ack) begin
                err_n   = (idx == 2'd1 || (idx == 2'd2 && we)) ? 2'b10 : 2'b01;
                state_n = ctl[1] ? DONE : RECOVER;
            end else if (ctl[1]) begin
                state_n = DONE;
            end else begin
                idx_n   = idx + 2'd1;
                ctl_n   = ctl_for(idx + 2'd1, we, dev, ra, wd);
                state_n = ISSUE;
            end
            RECOVER: begin
                ctl_n   = {ctl[11:4], 4'b1011};
                state_n = ISSUE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef I2C_REG_CTRL_TIMEOUT_EN
        cnt_n = (state == ISSUE) ? '0 : cnt;
        if (state == WAIT_LO || state == WAIT_HI) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CW'(TIMEOUT_CYCLES)) begin
                state_n = DONE;
                err_n   = 2'b11;
            end
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            err   <= '0;
            rdata <= '0;
            we    <= 1'b0;
            dev   <= '0;
            ra    <= '0;
            wd    <= '0;
            ctl   <= '0;
            start <= 1'b0;
`ifdef I2C_REG_CTRL_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_n;
            idx   <= idx_n;
            err   <= err_n;
            rdata <= rdata_n;
            we    <= we_n;
            dev   <= dev_n;
            ra    <= ra_n;
            wd    <= wd_n;
            ctl   <= ctl_n;
            start <= start_n;
`ifdef I2C_REG_CTRL_TIMEOUT_EN
            cnt   <= cnt_n;
`endif
        end
    end
    assign bus.busy      = state != IDLE && state != DONE;
    assign bus.done      = state == DONE;
    assign bus.err       = err;
    assign bus.rdata     = rdata;
    assign bus.tx_start  = start;
    assign bus.tx_data   = ctl[11:4];
    assign bus.rw        = ctl[3];
    assign bus.cnd_start = ctl[2];
    assign bus.cnd_stop  = ctl[1];
    assign bus.tx_ack    = ctl[0];
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: randomized commands against a byte-engine responder and a transaction-level model
module tb_i2c_reg_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    i2c_reg_ctrl_if bus();
    i2c_reg_ctrl #(.TIMEOUT_CYCLES(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int nack_at = -1;
    int t_start = 0;
    logic [7:0] rd = 8'h00;
    bit stall = 0;
    bit in_cmd = 0;
    logic [11:0] got[$];
    logic [11:0] exp_q[$];
    logic [1:0] exp_err;
    logic [7:0] exp_rdata = 8'h00;
    logic prev_start = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    // transaction-level model: byte list {data, rw, start, stop, ack} plus result
    function automatic void build(input logic we, input logic [6:0] dev, input logic [7:0] ra,
                                  input logic [7:0] wd, input int na, input logic [7:0] rdv);
        logic [11:0] seq[$];
        seq.push_back({dev, 1'b0, 4'b0100});
        seq.push_back({ra, 4'b0000});
        if (we) seq.push_back({wd, 4'b0010});
        else begin
            seq.push_back({dev, 1'b1, 4'b0100});
            seq.push_back({8'h00, 4'b1011});
        end
        exp_q.delete();
        exp_err = 2'b00;
        for (int i = 0; i < seq.size(); i++) begin
            exp_q.push_back(seq[i]);
            if (seq[i][3]) begin
                exp_rdata = rdv;
                break;
            end
            if (i == na) begin
                exp_err = (i == 1 || (we && i == 2)) ? 2'b10 : 2'b01;
                if (!seq[i][1]) exp_q.push_back({8'h00, 4'b1011});
                break;
            end
        end
    endfunction

    // responder standing in for i2c_raw
    initial begin
        bus.tx_ready = 1'b1;
        bus.rx_ack = 1'b0;
        bus.rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.tx_start && !rst) begin
                logic [11:0] b;
                int i, len, gap;
                bit ab;
                b = {bus.tx_data & {8{!bus.rw}}, bus.rw, bus.cnd_start, bus.cnd_stop, bus.tx_ack};
                i = got.size();
                got.push_back(b);
                t_start = cyc;
                len = $urandom_range(1, 6);
                @(posedge clk);
                #1 bus.tx_ready = 1'b0;
                ab = 0;
                for (int k = 0; k < len || stall; k++) begin
                    @(posedge clk);
                    if (rst) begin
                        ab = 1;
                        break;
                    end
                end
                #1;
                bus.rx_ack = b[3] ? 1'($urandom) : (i == nack_at);
                bus.rx_data = (b[3] && i == 3) ? rd : 8'($urandom);
                bus.tx_ready = 1'b1;
                if (!ab) begin
                    @(posedge clk);
                    #1 gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        bus.tx_ready = 1'b0;
                        repeat (gap) @(posedge clk);
                        #1 bus.tx_ready = 1'b1;
                    end
                end
            end
        end
    end

    // per-cycle protocol and busy/done checks
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_start) chk("start_when_ready", bus.tx_ready, 1);
            if (bus.tx_start) chk("start_one_cycle", prev_start, 0);
            if (bus.done) chk("done_one_cycle", prev_done, 0);
            if (in_cmd) chk("busy_vs_done", bus.busy, !bus.done);
            else chk("idle_outputs", {bus.busy, bus.done}, 0);
        end
        prev_start <= bus.tx_start;
        prev_done <= bus.done;
    end

    task automatic run_cmd(input logic we, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input int na, input logic [7:0] rdv, input bit tmo);
        bit ok;
        build(we, dev, ra, wd, na, rdv);
        if (tmo) begin
            exp_q = exp_q[0:0];
            exp_err = 2'b11;
        end
        nack_at = na;
        rd = rdv;
        stall = tmo;
        got.delete();
        @(posedge clk);
        #1;
        bus.req = 1'b1;
        bus.req_we = we;
        bus.dev_addr = dev;
        bus.reg_addr = ra;
        bus.wdata = wd;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        in_cmd = 1;
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            bus.req = 1'($urandom);
            bus.req_we = 1'($urandom);
            bus.dev_addr = 7'($urandom);
            bus.reg_addr = 8'($urandom);
            bus.wdata = 8'($urandom);
        end
        bus.req = 1'b0;
        chk("done_seen", ok, 1);
        if (ok) begin
            chk("err", bus.err, exp_err);
            chk("rdata", bus.rdata, exp_rdata);
            chk("byte_count", got.size(), exp_q.size());
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("byte", got[i], exp_q[i]);
            if (tmo) chk("timeout_cycles", cyc - t_start, 64);
        end
        stall = 0;
        @(posedge clk);
        #1 in_cmd = 0;
    endtask

    initial begin
        bus.req = 1'b0;
        bus.req_we = 1'b0;
        bus.dev_addr = '0;
        bus.reg_addr = '0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.done, bus.tx_start, bus.cnd_start, bus.cnd_stop, bus.rw,
                              bus.tx_ack, bus.err, bus.rdata, bus.tx_data}, 0);

        build(1'b1, 7'h1A, 8'h35, 8'hC3, -1, 8'h00);
        chk("model_w_b0", exp_q[0], 12'h344);
        chk("model_w_b2", exp_q[2], 12'hC32);
        run_cmd(1'b1, 7'h1A, 8'h35, 8'hC3, -1, 8'h00, 0);

        build(1'b0, 7'h1A, 8'h10, 8'h00, -1, 8'h5A);
        chk("model_r_b2", exp_q[2], 12'h354);
        chk("model_r_b3", exp_q[3], 12'h00B);
        run_cmd(1'b0, 7'h1A, 8'h10, 8'h00, -1, 8'h5A, 0);
        chk("read_result", bus.rdata, 8'h5A);

        build(1'b0, 7'h1A, 8'h10, 8'h00, 0, 8'h77);
        chk("model_nack0_len", exp_q.size(), 2);
        chk("model_nack0_err", exp_err, 2'b01);
        run_cmd(1'b0, 7'h1A, 8'h10, 8'h00, 0, 8'h77, 0);
        chk("nack0_rdata_kept", bus.rdata, 8'h5A);

        build(1'b1, 7'h22, 8'h01, 8'h99, 2, 8'h00);
        chk("model_wnack_len", exp_q.size(), 3);
        chk("model_wnack_err", exp_err, 2'b10);
        run_cmd(1'b1, 7'h22, 8'h01, 8'h99, 2, 8'h00, 0);

        for (int n = 0; n < 40; n++)
            run_cmd(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2)), 8'($urandom), 0);

`ifdef I2C_REG_CTRL_TIMEOUT_EN
        run_cmd(1'b1, 7'h1A, 8'h35, 8'hC3, -1, 8'h00, 1);
`endif

        nack_at = -1;
        stall = 0;
        got.delete();
        @(posedge clk);
        #1;
        bus.req = 1'b1;
        bus.req_we = 1'b0;
        bus.dev_addr = 7'h33;
        bus.reg_addr = 8'h44;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        in_cmd = 1;
        for (int c = 0; c < 500 && got.size() < 2; c++) @(negedge clk);
        chk("midrst_progress", got.size() >= 2, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_cmd = 0;
        exp_rdata = 8'h00;
        @(negedge clk);
        chk("midrst_outputs", {bus.busy, bus.done, bus.tx_start, bus.cnd_start, bus.cnd_stop, bus.rw,
                               bus.tx_ack, bus.err, bus.rdata, bus.tx_data}, 0);
        run_cmd(1'b0, 7'h1A, 8'h10, 8'h00, -1, 8'hA5, 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
